// File: rtl/main_net_pkg.sv
// -----------------------------------------------------------------------------
// main_net_pkg
// Shared constants for the main-network weight memory: layer codes, the
// default per-layer weight counts, the write-back FSM state type and a small
// helper for sizing RAM address ports.
// -----------------------------------------------------------------------------
package main_net_pkg;

    // Layer codes carried on both the read-request and write-back buses.
    // Code 2'b00 is not a layer and is always rejected.
    localparam logic [1:0] LAYER_NONE     = 2'b00;
    localparam logic [1:0] LAYER_HIDDEN_1 = 2'b01;
    localparam logic [1:0] LAYER_HIDDEN_2 = 2'b10;
    localparam logic [1:0] LAYER_OUTPUT   = 2'b11;

    // Word counts for the default 2-32-32-3 network. Each node carries one
    // weight per input plus a bias word.
    localparam int L1_WEIGHTS   = 32 * (2 + 1);   //   96
    localparam int L2_WEIGHTS   = 32 * (32 + 1);  // 1056
    localparam int L3_WEIGHTS   = 3 * (32 + 1);   //   99
    localparam int TOTAL_WEIGHT = L1_WEIGHTS + L2_WEIGHTS + L3_WEIGHTS; // 1251

    // Write-back sequencing.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        SWAP    = 2'd2
    } state_t;

    // Address width needed to index a RAM of the given depth (at least 1 bit).
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/main_net_weight_bank.sv
// -----------------------------------------------------------------------------
// main_net_weight_bank
// Simple dual-port weight RAM: one write port, one registered read port.
// A read and a write to the same address on the same edge return the old
// word (read-first), which falls out of the non-blocking update below.
// Contents are deliberately not reset.
//
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   re_i     read enable; rdata_o holds its value when low
//   raddr_i  read address
//   rdata_o  registered read data, valid the cycle after re_i
// -----------------------------------------------------------------------------
module main_net_weight_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 96,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/main_net_weight_memory.sv
// -----------------------------------------------------------------------------
// main_net_weight_memory
// Double-buffered store for the main-network weights (hidden-1, hidden-2,
// output layer). Reads are served from the active bank with a fixed 2-cycle
// latency; the streamed write-back fills the shadow bank and, once every
// word of a set has been counted, the banks swap in a single edge.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_weight_valid_request   read request strobe
//   i_weight_layer_request   layer code (01 hidden1, 10 hidden2, 11 output)
//   i_weight_addr_request    word address within the layer
//   o_weight_valid           read response strobe (2 cycles after request)
//   o_weight_layer/addr      echoed request layer/address
//   o_weight                 weight data
//   i_new_weight_valid       write-back strobe
//   i_new_weight_layer/addr  write-back layer/address
//   i_new_weight             write-back data
//   o_update_done            one-cycle pulse on the edge the banks swap
//   o_weights_loaded         sticky, set at the first swap
//   o_req_error              one-cycle pulse for a rejected read
//   o_wr_error               one-cycle pulse for a rejected write
// -----------------------------------------------------------------------------
module main_net_weight_memory
    import main_net_pkg::*;
#(
    parameter int DATA_WIDTH                    = 32,
    parameter int LAYER_WIDTH                   = 2,
    parameter int NUMBER_OF_INPUT_NODE          = 2,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int NUMBER_OF_OUTPUT_NODE         = 3,
    parameter int WEIGHT_COUNTER_WIDTH          = 11
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_weight_valid_request,
    input  logic [LAYER_WIDTH-1:0]          i_weight_layer_request,
    input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_weight_addr_request,
    output logic                            o_weight_valid,
    output logic [LAYER_WIDTH-1:0]          o_weight_layer,
    output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
    output logic [DATA_WIDTH-1:0]           o_weight,
    input  logic                            i_new_weight_valid,
    input  logic [LAYER_WIDTH-1:0]          i_new_weight_layer,
    input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_new_weight_addr,
    input  logic [DATA_WIDTH-1:0]           i_new_weight,
    output logic                            o_update_done,
    output logic                            o_weights_loaded,
    output logic                            o_req_error,
    output logic                            o_wr_error
);

    localparam int CW = WEIGHT_COUNTER_WIDTH;
    localparam int LW = LAYER_WIDTH;

    localparam int L1_SIZE = NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1);
    localparam int L2_SIZE = NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1);
    localparam int L3_SIZE = NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1);
    localparam int TOTAL   = L1_SIZE + L2_SIZE + L3_SIZE;

    localparam int L1_AW = addr_bits(L1_SIZE);
    localparam int L2_AW = addr_bits(L2_SIZE);
    localparam int L3_AW = addr_bits(L3_SIZE);

    localparam logic [CW-1:0] L1_LIMIT    = CW'(L1_SIZE);
    localparam logic [CW-1:0] L2_LIMIT    = CW'(L2_SIZE);
    localparam logic [CW-1:0] L3_LIMIT    = CW'(L3_SIZE);
    localparam logic [CW-1:0] LAST_COUNT  = CW'(TOTAL - 1);
    localparam logic [CW-1:0] FIRST_COUNT = CW'(1);

    localparam logic [LW-1:0] LYR_H1  = LW'(LAYER_HIDDEN_1);
    localparam logic [LW-1:0] LYR_H2  = LW'(LAYER_HIDDEN_2);
    localparam logic [LW-1:0] LYR_OUT = LW'(LAYER_OUTPUT);

    // Layer code names a real layer and the address lies inside it.
    function automatic logic in_range(input logic [LW-1:0] layer,
                                      input logic [CW-1:0] addr);
        logic ok;
        ok = 1'b0;
        case (layer)
            LYR_H1:  ok = (addr < L1_LIMIT);
            LYR_H2:  ok = (addr < L2_LIMIT);
            LYR_OUT: ok = (addr < L3_LIMIT);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ------------------------------------------------------------------
    // Request / write qualification
    // ------------------------------------------------------------------
    logic req_ok, req_bad, wr_ok, wr_bad;

    assign req_ok  = i_weight_valid_request &&  in_range(i_weight_layer_request, i_weight_addr_request);
    assign req_bad = i_weight_valid_request && !in_range(i_weight_layer_request, i_weight_addr_request);
    assign wr_ok   = i_new_weight_valid     &&  in_range(i_new_weight_layer, i_new_weight_addr);
    assign wr_bad  = i_new_weight_valid     && !in_range(i_new_weight_layer, i_new_weight_addr);

    // ------------------------------------------------------------------
    // Write-back FSM, counter and bank select
    // ------------------------------------------------------------------
    state_t        state_q;
    logic [CW-1:0] wr_cnt_q;
    logic          bank_sel_q;
    logic          update_done_q;
    logic          loaded_q;
    logic          wr_bank;

    // Normally the shadow bank is ~bank_sel. In the SWAP cycle bank_sel is
    // about to flip, so the shadow of the *next* set is the current bank_sel.
    assign wr_bank = (state_q == SWAP) ? bank_sel_q : ~bank_sel_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_cnt_q      <= '0;
            bank_sel_q    <= 1'b0;
            update_done_q <= 1'b0;
            loaded_q      <= 1'b0;
        end else begin
            update_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_ok) begin
                        wr_cnt_q <= FIRST_COUNT;
                        state_q  <= LOADING;
                    end
                end
                LOADING: begin
                    if (wr_ok) begin
                        wr_cnt_q <= wr_cnt_q + 1'b1;
                        if (wr_cnt_q == LAST_COUNT) begin
                            state_q <= SWAP;
                        end
                    end
                end
                SWAP: begin
                    bank_sel_q    <= ~bank_sel_q;
                    update_done_q <= 1'b1;
                    loaded_q      <= 1'b1;
                    // A write landing in the swap cycle opens the next set.
                    if (wr_ok) begin
                        wr_cnt_q <= FIRST_COUNT;
                        state_q  <= LOADING;
                    end else begin
                        wr_cnt_q <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    wr_cnt_q <= '0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Weight banks: [bank] per layer. Only the bank named by the current
    // bank_sel is read, and the read is taken on the request edge so a
    // write to that bank on the same edge is seen as old data.
    // ------------------------------------------------------------------
    logic [1:0][DATA_WIDTH-1:0] l1_rdata, l2_rdata, l3_rdata;
    logic rd_l1, rd_l2, rd_l3, we_l1, we_l2, we_l3;

    assign rd_l1 = req_ok && (i_weight_layer_request == LYR_H1);
    assign rd_l2 = req_ok && (i_weight_layer_request == LYR_H2);
    assign rd_l3 = req_ok && (i_weight_layer_request == LYR_OUT);
    assign we_l1 = wr_ok  && (i_new_weight_layer == LYR_H1);
    assign we_l2 = wr_ok  && (i_new_weight_layer == LYR_H2);
    assign we_l3 = wr_ok  && (i_new_weight_layer == LYR_OUT);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        main_net_weight_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (L1_SIZE),
            .ADDR_WIDTH (L1_AW)
        ) u_l1 (
            .clk_i   (clk),
            .we_i    (we_l1 && (wr_bank == 1'(b))),
            .waddr_i (i_new_weight_addr[L1_AW-1:0]),
            .wdata_i (i_new_weight),
            .re_i    (rd_l1 && (bank_sel_q == 1'(b))),
            .raddr_i (i_weight_addr_request[L1_AW-1:0]),
            .rdata_o (l1_rdata[b])
        );

        main_net_weight_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (L2_SIZE),
            .ADDR_WIDTH (L2_AW)
        ) u_l2 (
            .clk_i   (clk),
            .we_i    (we_l2 && (wr_bank == 1'(b))),
            .waddr_i (i_new_weight_addr[L2_AW-1:0]),
            .wdata_i (i_new_weight),
            .re_i    (rd_l2 && (bank_sel_q == 1'(b))),
            .raddr_i (i_weight_addr_request[L2_AW-1:0]),
            .rdata_o (l2_rdata[b])
        );

        main_net_weight_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (L3_SIZE),
            .ADDR_WIDTH (L3_AW)
        ) u_l3 (
            .clk_i   (clk),
            .we_i    (we_l3 && (wr_bank == 1'(b))),
            .waddr_i (i_new_weight_addr[L3_AW-1:0]),
            .wdata_i (i_new_weight),
            .re_i    (rd_l3 && (bank_sel_q == 1'(b))),
            .raddr_i (i_weight_addr_request[L3_AW-1:0]),
            .rdata_o (l3_rdata[b])
        );
    end

    // ------------------------------------------------------------------
    // Read pipeline. Stage 0 carries the tag (layer, addr, bank) alongside
    // the RAM read; stage 1 holds the selected word; the output registers
    // present it. Each response uses the bank tagged at request time, so
    // a swap mid-flight cannot mix sets.
    // ------------------------------------------------------------------
    logic                  s0_vld_q, s0_bank_q, s0_rerr_q, s0_werr_q;
    logic [LW-1:0]         s0_layer_q;
    logic [CW-1:0]         s0_addr_q;
    logic                  s1_vld_q;
    logic [LW-1:0]         s1_layer_q;
    logic [CW-1:0]         s1_addr_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic [DATA_WIDTH-1:0] rd_mux;

    logic                  weight_valid_q, req_error_q, wr_error_q;
    logic [LW-1:0]         weight_layer_q;
    logic [CW-1:0]         weight_addr_q;
    logic [DATA_WIDTH-1:0] weight_q;

    always_comb begin
        rd_mux = '0;
        case (s0_layer_q)
            LYR_H1:  rd_mux = l1_rdata[s0_bank_q];
            LYR_H2:  rd_mux = l2_rdata[s0_bank_q];
            LYR_OUT: rd_mux = l3_rdata[s0_bank_q];
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_vld_q       <= 1'b0;
            s0_bank_q      <= 1'b0;
            s0_layer_q     <= '0;
            s0_addr_q      <= '0;
            s0_rerr_q      <= 1'b0;
            s0_werr_q      <= 1'b0;
            s1_vld_q       <= 1'b0;
            s1_layer_q     <= '0;
            s1_addr_q      <= '0;
            s1_data_q      <= '0;
            weight_valid_q <= 1'b0;
            weight_layer_q <= '0;
            weight_addr_q  <= '0;
            weight_q       <= '0;
            req_error_q    <= 1'b0;
            wr_error_q     <= 1'b0;
        end else begin
            // stage 0: tag capture
            s0_vld_q  <= req_ok;
            s0_rerr_q <= req_bad;
            s0_werr_q <= wr_bad;
            if (req_ok) begin
                s0_layer_q <= i_weight_layer_request;
                s0_addr_q  <= i_weight_addr_request;
                s0_bank_q  <= bank_sel_q;
            end
            // stage 1: bank select
            s1_vld_q <= s0_vld_q;
            if (s0_vld_q) begin
                s1_layer_q <= s0_layer_q;
                s1_addr_q  <= s0_addr_q;
                s1_data_q  <= rd_mux;
            end
            // output registers
            weight_valid_q <= s1_vld_q;
            if (s1_vld_q) begin
                weight_layer_q <= s1_layer_q;
                weight_addr_q  <= s1_addr_q;
                weight_q       <= s1_data_q;
            end
            // errors are reported one edge after the offending strobe
            req_error_q <= s0_rerr_q;
            wr_error_q  <= s0_werr_q;
        end
    end

    assign o_weight_valid   = weight_valid_q;
    assign o_weight_layer   = weight_layer_q;
    assign o_weight_addr    = weight_addr_q;
    assign o_weight         = weight_q;
    assign o_update_done    = update_done_q;
    assign o_weights_loaded = loaded_q;
    assign o_req_error      = req_error_q;
    assign o_wr_error       = wr_error_q;

endmodule

// File: doc/main_net_weight_memory.md
Name: main_net_weight_memory

Overview:
Holds the main-network weights for hidden layer 1, hidden layer 2 and the output layer. It is the responder side of the weight-update handshake. It answers weight read requests (layer + address) with the stored weight after a fixed 2-cycle latency. It also accepts the streamed new-weight write-back (1251 words) into a shadow bank, then swaps banks atomically so readers never see a partially updated set.

Parameters:
DATA_WIDTH, 32, weight word width (IEEE-754 single)
LAYER_WIDTH, 2, layer code width
NUMBER_OF_INPUT_NODE, 2, network inputs
NUMBER_OF_HIDDEN_NODE_LAYER_1, 32, hidden-1 nodes
NUMBER_OF_HIDDEN_NODE_LAYER_2, 32, hidden-2 nodes
NUMBER_OF_OUTPUT_NODE, 3, output nodes
WEIGHT_COUNTER_WIDTH, 11, address/counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_weight_valid_request  in  1  read request strobe
i_weight_layer_request  in  LAYER_WIDTH  01 hidden1, 10 hidden2, 11 output
i_weight_addr_request  in  WEIGHT_COUNTER_WIDTH  word address within layer
o_weight_valid  out  1  read response strobe
o_weight_layer  out  LAYER_WIDTH  echoed layer
o_weight_addr  out  WEIGHT_COUNTER_WIDTH  echoed address
o_weight  out  DATA_WIDTH  weight data
i_new_weight_valid  in  1  write strobe
i_new_weight_layer  in  LAYER_WIDTH  write layer
i_new_weight_addr  in  WEIGHT_COUNTER_WIDTH  write address
i_new_weight  in  DATA_WIDTH  write data
o_update_done  out  1  one-cycle pulse on bank swap
o_weights_loaded  out  1  sticky; set at first commit
o_req_error  out  1  one-cycle pulse, rejected read
o_wr_error  out  1  one-cycle pulse, rejected write

Behaviour:
Clock and reset:
- One clock, clk.
- rst is asynchronous, active-high.
- On rst: every output is 0, bank_sel=0, write counter=0, state=IDLE.
- RAM contents are not reset.

Layer sizes:
- L1 = 96 (32x3), L2 = 1056 (32x33), L3 = 99 (3x33).
- TOTAL = 1251.
- Legal request: layer in {01,10,11} and addr < size(layer).

Read path:
- Two banks per layer; reads always use bank bank_sel.
- Stage 0 (edge N): a legal request captures layer, addr and the current bank_sel as a tag.
- Stage 1: RAM read, registered.
- Edge N+2: o_weight_valid=1 with echoed layer/addr.
- Fully pipelined: one request per cycle, responses in request order.
- Illegal request: no response; o_req_error pulses at edge N+1.

Write path:
- Legal writes go to bank ~bank_sel.
- Illegal writes (layer 00 or addr out of range) are ignored, not counted, and pulse o_wr_error at edge N+1.
- Writes may arrive in any order. Duplicate addresses are counted again; no tracking.

State machine:
- IDLE -> LOADING on the first legal write (counter becomes 1).
- LOADING: each legal write increments the counter.
- The write making counter == TOTAL -> SWAP.
- SWAP (one cycle):
  - bank_sel toggles at the next edge.
  - o_update_done pulses.
  - o_weights_loaded is set.
  - counter is cleared.
  - -> IDLE.
- A legal write during SWAP targets the post-swap inactive bank (the current bank_sel bank).
  - It counts as write 1 of the next set; next state is LOADING.

Hazards:
- Read-during-write to the same bank and address returns old data (read-first).
- In-flight reads complete from their tagged bank, so a swap mid-pipeline never mixes sets.

Reset mid-operation:
- In-flight responses are discarded.
- A partial set is abandoned; the counter is cleared.
- bank_sel returns to 0 and o_weights_loaded to 0.

Simultaneous read and write:
- Always permitted; they target different banks except during the SWAP case above.

Decomposition:
Package main_net_pkg holds:
- layer codes (LAYER_HIDDEN_1=01, LAYER_HIDDEN_2=10, LAYER_OUTPUT=11);
- per-layer word counts and TOTAL_WEIGHT=1251;
- the state enum {IDLE, LOADING, SWAP}.

Sub-module main_net_weight_bank:
- simple dual-port RAM: one write port, one registered read port, read-first;
- instantiated once per layer per bank (6 instances).
- Top-level holds request pipeline, range check, counter, FSM and the output mux.

Test Plan:
1. Assert rst for 3 cycles mid-traffic -> all outputs 0 immediately (async); no o_weight_valid after release until a new request.
2. Stream 1251 legal writes, data = {layer,addr} pattern -> o_update_done pulses once, one cycle after the last write; o_weights_loaded=1; read layer 10 addr 1055 -> o_weight=pattern(10,1055) exactly 2 cycles later.
3. Back-to-back reads (01,0),(10,500),(11,98),(01,95) -> four consecutive responses at latency 2, in order, layer/addr echoed.
4. Read (01,96), read (00,0), write (11,99) -> no response; o_req_error pulses twice; o_wr_error pulses once. A following 1250 legal writes do not commit; write 1251 commits.
5. Second load with new pattern while reading (10,7) every cycle -> old value until the swap edge, new value after. A request issued the cycle before the swap returns the old value.
6. Assert rst after 500 writes, then 1251 writes -> commit only at the 1251st post-reset write; bank_sel ends at 1.
